// File: rtl/cpu_input_pkg.sv
// Shared types and constants for the front-panel operand input stage.
package cpu_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_e;

  localparam int unsigned LD_A  = 0;
  localparam int unsigned LD_B  = 1;
  localparam int unsigned LD_OP = 2;
  localparam int unsigned LD_W  = 3;

  localparam int unsigned OPND_W = 10;
  localparam int unsigned OP_W   = 8;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus press/release debounce FSM for one active-low button.
// Optional AUTO_REPEAT_EN adds periodic press events while the button stays held.
module button_debouncer
  import cpu_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press,
  output logic held
);

  localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_sync;
  debounce_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_d, held_d;

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], btn_n};
  end

  assign btn_sync = sync_q[1];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d, rpt_inc;

  assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press   <= 1'b0;
      held    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= press_d;
      held    <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (!btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rpt_q >= RPT_LAST) begin
            press_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_inc;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (!btn_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

endmodule

// File: rtl/operand_input_loader.sv
// Front-panel input stage: debounced buttons latch switch values into A/B/Op.
// Build with AUTO_REPEAT_EN defined to get auto-repeat loads while a button is held.
module operand_input_loader #(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned OPND_W          = cpu_input_pkg::OPND_W,
  parameter int unsigned OP_W            = cpu_input_pkg::OP_W,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              A_button,
  input  logic              B_button,
  input  logic              Op_button,
  input  logic              cin_button,
  output logic [OPND_W-1:0] A,
  output logic [OPND_W-1:0] B,
  output logic [OP_W-1:0]   Op,
  output logic              cin,
  output logic [2:0]        load_strb,
  output logic              all_loaded
);

  import cpu_input_pkg::LD_A;
  import cpu_input_pkg::LD_B;
  import cpu_input_pkg::LD_OP;

  logic [DATA_W-1:0] data_s1, data_s2;
  logic [2:0]        press, held, loaded;
  logic              cin_press, cin_held;
  logic              unused;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_a (
    .clk(clk), .reset(reset), .btn_n(A_button), .press(press[LD_A]), .held(held[LD_A])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_b (
    .clk(clk), .reset(reset), .btn_n(B_button), .press(press[LD_B]), .held(held[LD_B])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_op (
    .clk(clk), .reset(reset), .btn_n(Op_button), .press(press[LD_OP]), .held(held[LD_OP])
  );
  // Carry-in is a level only; its press pulse is deliberately ignored.
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_cin (
    .clk(clk), .reset(reset), .btn_n(cin_button), .press(cin_press), .held(cin_held)
  );

  assign unused = ^{held, cin_press, data_s2[DATA_W-1:OPND_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      data_s1 <= data_in;
      data_s2 <= data_s1;
    end
  end

  // All strobed registers load the same synchronized switch sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      A          <= '0;
      B          <= '0;
      Op         <= '0;
      cin        <= 1'b0;
      load_strb  <= '0;
      loaded     <= '0;
      all_loaded <= 1'b0;
    end else begin
      load_strb  <= press;
      cin        <= cin_held;
      loaded     <= loaded | press;
      all_loaded <= &(loaded | press);
      if (press[LD_A])  A  <= data_s2[OPND_W-1:0];
      if (press[LD_B])  B  <= data_s2[OPND_W-1:0];
      if (press[LD_OP]) Op <= data_s2[OP_W-1:0];
    end
  end

endmodule

// File: tb/tb_operand_input_loader.sv
// Directed bench for operand_input_loader with short debounce/repeat periods.
module tb_operand_input_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        A_button, B_button, Op_button, cin_button;
  logic [9:0]  A, B;
  logic [7:0]  Op;
  logic        cin;
  logic [2:0]  load_strb;
  logic        all_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  operand_input_loader #(
    .DATA_W(16), .OPND_W(10), .OP_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .A_button(A_button), .B_button(B_button), .Op_button(Op_button), .cin_button(cin_button),
    .A(A), .B(B), .Op(Op), .cin(cin), .load_strb(load_strb), .all_loaded(all_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick ncyc cycles; release buttons in rel_mask {cin,Op,B,A} after tick rel_at.
  task automatic watch(input int ncyc, input int rel_at, input logic [3:0] rel_mask,
                       output int first, output int cnt, output logic [2:0] val);
    first = -1;
    cnt   = 0;
    val   = '0;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (load_strb != 3'b000) begin
        if (first < 0) begin
          first = i;
          val   = load_strb;
        end
        cnt++;
      end
      if (i == rel_at) begin
        if (rel_mask[0]) A_button   = 1'b1;
        if (rel_mask[1]) B_button   = 1'b1;
        if (rel_mask[2]) Op_button  = 1'b1;
        if (rel_mask[3]) cin_button = 1'b1;
      end
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_A"}, 32'(A), 32'h0);
    check({pfx, "_B"}, 32'(B), 32'h0);
    check({pfx, "_Op"}, 32'(Op), 32'h0);
    check({pfx, "_cin"}, 32'(cin), 32'h0);
    check({pfx, "_strb"}, 32'(load_strb), 32'h0);
    check({pfx, "_all"}, 32'(all_loaded), 32'h0);
  endtask

  initial begin
    int          first, cnt, rise, fall, gcnt;
    logic [2:0]  val;
    logic [6:0]  glitch;
    int          exp_rpt;

    reset = 1'b1; data_in = '0;
    A_button = 1'b1; B_button = 1'b1; Op_button = 1'b1; cin_button = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    repeat (20) tick();
    check_reset_values("rst");

    // Single A press
    data_in = 16'h03A5;
    repeat (3) tick();
    A_button = 1'b0;
    watch(12, 10, 4'b0001, first, cnt, val);
    check("a_lat", 32'(first), 32'd7);
    check("a_strb", 32'(val), 32'h1);
    check("a_cnt", 32'(cnt), 32'd1);
    check("a_val", 32'(A), 32'h3A5);
    check("a_notall", 32'(all_loaded), 32'h0);
    watch(15, 0, 4'b0000, first, cnt, val);
    check("a_rel", 32'(cnt), 32'd0);

    // Glitchy A: low 3, high 1, low 3
    data_in = 16'h0111;
    glitch = 7'b0001000;
    gcnt = 0;
    for (int i = 6; i >= 0; i--) begin
      A_button = glitch[i];
      tick();
      if (load_strb != 3'b000) gcnt++;
    end
    A_button = 1'b1;
    watch(20, 0, 4'b0000, first, cnt, val);
    check("glitch_cnt", 32'(gcnt + cnt), 32'd0);
    check("glitch_A", 32'(A), 32'h3A5);

    // Simultaneous B and Op
    data_in = 16'hFF7C;
    repeat (3) tick();
    B_button = 1'b0; Op_button = 1'b0;
    watch(12, 10, 4'b0110, first, cnt, val);
    check("bop_lat", 32'(first), 32'd7);
    check("bop_strb", 32'(val), 32'h6);
    check("bop_cnt", 32'(cnt), 32'd1);
    check("bop_B", 32'(B), 32'h37C);
    check("bop_Op", 32'(Op), 32'h7C);
    check("bop_A", 32'(A), 32'h3A5);
    check("bop_all", 32'(all_loaded), 32'h1);
    watch(15, 0, 4'b0000, first, cnt, val);

    // cin level: low 8 cycles then high
    rise = -1; fall = -1; gcnt = 0;
    cin_button = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (cin && rise < 0) rise = i;
      if (!cin && rise >= 0 && fall < 0) fall = i;
      if (load_strb != 3'b000) gcnt++;
      if (i == 8) cin_button = 1'b1;
    end
    check("cin_rise", 32'(rise), 32'd7);
    check("cin_fall", 32'(fall), 32'd15);
    check("cin_strb", 32'(gcnt), 32'd0);

    // Long Op hold
`ifdef AUTO_REPEAT_EN
    exp_rpt = 3;
`else
    exp_rpt = 1;
`endif
    Op_button = 1'b0;
    watch(60, 40, 4'b0100, first, cnt, val);
    check("hold_lat", 32'(first), 32'd7);
    check("hold_strb", 32'(val), 32'h4);
    check("hold_cnt", 32'(cnt), 32'(exp_rpt));
    check("hold_Op", 32'(Op), 32'h7C);

    // Reset in the middle of PRESS_WAIT
    data_in = 16'h0155;
    repeat (3) tick();
    A_button = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    A_button = 1'b1;
    gcnt = 0;
    repeat (2) begin
      tick();
      if (load_strb != 3'b000) gcnt++;
    end
    reset = 1'b0;
    watch(20, 0, 4'b0000, first, cnt, val);
    check("midrst_strb", 32'(gcnt + cnt), 32'd0);
    check_reset_values("midrst");

    // Button held through reset deassertion loads after a full debounce
    A_button = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    watch(12, 10, 4'b0001, first, cnt, val);
    check("thru_lat", 32'(first), 32'd7);
    check("thru_cnt", 32'(cnt), 32'd1);
    check("thru_A", 32'(A), 32'h155);
    check("thru_all", 32'(all_loaded), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
